status_frame_rx: RTL
====================

// Module: status_frame_rx
// PURPOSE
//  Controller-side receiver for the unit's upstream status link (the unit's `sent` line).
//  Decodes pulse-width-coded frames into a 16-bit status word and reports frame, parity
//  and link-loss events. Sits on the controller board, fed from the fibre/opto receiver.
//  Line coding: idle low; start = 10 us high; then 16 data bits MSB first; then 1 even-parity
//  bit. Each bit is a high pulse: '0' = 1 us, '1' = 3 us, bit period 5 us. Clock is 40 MHz.
// PARAMETERS
//  FILT_LEN     4      consecutive equal samples required to accept a line level change
//  W0_MIN       20     min high width (clk) for a '0' bit
//  W0_MAX       60     max high width for a '0' bit
//  W1_MIN       100    min high width for a '1' bit
//  W1_MAX       140    max high width for a '1' bit
//  WS_MIN       360    min high width for a start pulse
//  WS_MAX       440    max high width for a start pulse
//  GAP_MAX      400    max low time between pulses inside a frame
//  LOSS_TIMEOUT 40000  clk cycles without a valid frame before link_ok drops (1 ms)
// PORTS
//  clk          in   1   system clock, 40 MHz
//  rst_n        in   1   asynchronous active-low reset
//  sent_in      in   1   raw serial line from the unit; asynchronous to clk
//  data_out     out  16  last good status word; updates only on a valid frame
//  frame_valid  out  1   1-cycle pulse when data_out is updated
//  err_parity   out  1   1-cycle pulse on a parity mismatch
//  err_frame    out  1   1-cycle pulse on a bad width, a gap timeout, or a resync
//  link_ok      out  1   high while valid frames keep arriving
//  frame_cnt    out  8   count of valid frames; wraps 255->0
//  err_cnt      out  8   count of parity and frame errors; saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, filtered level = low, all counters = 0.
//  - Reset mid-frame aborts the frame. No partial data reaches data_out.
//  Input path:
//  - 2-FF synchroniser, then the filter.
//  - The filtered level flips only after FILT_LEN consecutive synchronised samples at the new level.
//  - Pulses shorter than FILT_LEN clk are invisible.
//  Width measurement:
//  - hi_cnt counts clk while the filtered level is high, saturating at 1023.
//  - lo_cnt counts clk while it is low, saturating at 1023.
//  - Both clear on the opposite edge. Pulses are classified on each filtered falling edge.
//  FSM:
//  - IDLE: on a fall with width in [WS_MIN,WS_MAX], clear bit_cnt and go to DATA. Any other width: stay, no error.
//  - DATA: on a fall, W0 window shifts in 0 and W1 window shifts in 1; bit_cnt++.
//  - DATA, start-width pulse: pulse err_frame, clear bit_cnt, stay in DATA (resync).
//  - DATA, any other width: pulse err_frame, go to IDLE.
//  - DATA, lo_cnt > GAP_MAX: pulse err_frame, go to IDLE.
//  - DATA, when the 17th bit (parity) is classified: if XOR of all 17 bits == 0, load data_out,
//    pulse frame_valid, frame_cnt++; else pulse err_parity and hold data_out. Then go to IDLE.
//  Latency and priority:
//  - frame_valid/err_* assert exactly FILT_LEN+3 clk after the first clk edge sampling sent_in low
//    at the end of the parity pulse.
//  - err_parity and err_frame never assert in the same cycle.
//  - err_cnt increments by 1 per error pulse.
//  Edge cases:
//  - A line stuck high saturates hi_cnt; its eventual fall is out of every window and is handled
//    as an invalid width.
//  - A line stuck low in DATA triggers the gap timeout.
//  link_ok:
//  - Set with frame_valid.
//  - Cleared when LOSS_TIMEOUT clk have elapsed since the last frame_valid.
//  - The timeout counter reloads on every frame_valid.
// TESTING
//  1. Good frame, data 16'hA5C3, parity 0 -> data_out=A5C3, one frame_valid pulse, frame_cnt=1, link_ok=1.
//  2. Same frame, parity bit inverted -> err_parity pulse, data_out unchanged, err_cnt=1.
//  3. 2-clk high glitches inside gaps of a good 16'h0001 frame -> ignored; frame_valid, data_out=0001.
//  4. Bit pulse of 80 clk (2 us) -> err_frame, FSM IDLE; next good frame 16'hFFFF decodes correctly.
//  5. Start pulse after 7 data bits, then a full good frame 16'h1234 -> one err_frame, then
//     data_out=1234; a 500-clk low gap mid-frame -> err_frame.
//  6. After a valid frame, idle for 40000 clk -> link_ok drops on exactly that cycle.
//     rst_n low mid-frame -> all outputs 0 at once; the next good frame decodes.

Source files
------------

// File: rtl/status_frame_rx.sv
// status_frame_rx: decodes pulse-width-coded status frames from the unit's sent line into a 16-bit word
module status_frame_rx #(
  parameter int FILT_LEN     = 4,
  parameter int W0_MIN       = 20,
  parameter int W0_MAX       = 60,
  parameter int W1_MIN       = 100,
  parameter int W1_MAX       = 140,
  parameter int WS_MIN       = 360,
  parameter int WS_MAX       = 440,
  parameter int GAP_MAX      = 400,
  parameter int LOSS_TIMEOUT = 40000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sent_in,
  output logic [15:0] data_out,
  output logic        frame_valid,
  output logic        err_parity,
  output logic        err_frame,
  output logic        link_ok,
  output logic [7:0]  frame_cnt,
  output logic [7:0]  err_cnt
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(LOSS_TIMEOUT);
  typedef enum logic {IDLE, DATA} state_t;
  state_t state;
  logic s1, s2, lvl, lvl_d, fall_r;
  logic [FW-1:0] fcnt;
  logic [9:0] hi_cnt, lo_cnt, w_r;
  logic [4:0] bit_cnt;
  logic [15:0] sh;
  logic [TW-1:0] tmo;
  logic is0, is1, iss, bit_ok, last, par_ok, in_data, good, e_par, e_frm;
  always_comb begin
    is0 = w_r >= 10'(W0_MIN) && w_r <= 10'(W0_MAX);
    is1 = w_r >= 10'(W1_MIN) && w_r <= 10'(W1_MAX);
    iss = w_r >= 10'(WS_MIN) && w_r <= 10'(WS_MAX);
    bit_ok = is0 | is1;
    last = bit_cnt == 5'd16;
    par_ok = ~^{sh, is1};
    in_data = state == DATA;
    good = in_data && fall_r && bit_ok && last && par_ok;
    e_par = in_data && fall_r && bit_ok && last && !par_ok;
    e_frm = in_data && (fall_r ? !bit_ok : lo_cnt > 10'(GAP_MAX));
  end
  // fall_r/w_r add one stage so classification sees the completed high width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl <= 1'b0;
      lvl_d <= 1'b0;
      fcnt <= '0;
      hi_cnt <= '0;
      lo_cnt <= '0;
      w_r <= '0;
      fall_r <= 1'b0;
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      data_out <= '0;
      frame_valid <= 1'b0;
      err_parity <= 1'b0;
      err_frame <= 1'b0;
      link_ok <= 1'b0;
      tmo <= '0;
      frame_cnt <= '0;
      err_cnt <= '0;
    end else begin
      s1 <= sent_in;
      s2 <= s1;
      if (s2 != lvl) begin
        fcnt <= fcnt == FW'(FILT_LEN - 1) ? '0 : fcnt + 1'b1;
        if (fcnt == FW'(FILT_LEN - 1)) lvl <= s2;
      end else fcnt <= '0;
      lvl_d <= lvl;
      hi_cnt <= !lvl ? '0 : &hi_cnt ? hi_cnt : hi_cnt + 10'd1;
      lo_cnt <= lvl ? '0 : &lo_cnt ? lo_cnt : lo_cnt + 10'd1;
      fall_r <= lvl_d & ~lvl;
      w_r <= hi_cnt;
      frame_valid <= good;
      err_parity <= e_par;
      err_frame <= e_frm;
      if (state == IDLE) begin
        if (fall_r && iss) begin
          state <= DATA;
          bit_cnt <= '0;
        end
      end else if (fall_r) begin
        if (bit_ok && last) state <= IDLE;
        else if (bit_ok) begin
          sh <= {sh[14:0], is1};
          bit_cnt <= bit_cnt + 5'd1;
        end else if (iss) bit_cnt <= '0;
        else state <= IDLE;
      end else if (e_frm) state <= IDLE;
      if (good) begin
        data_out <= sh;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if ((e_par | e_frm) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (good) begin
        link_ok <= 1'b1;
        tmo <= '0;
      end else if (link_ok) begin
        tmo <= tmo + 1'b1;
        if (tmo == TW'(LOSS_TIMEOUT - 1)) link_ok <= 1'b0;
      end
    end
  end
endmodule
